// File: rtl/atf_pkg.sv
// Shared types and constants for the auto-track-frequency period meter.
package atf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } atf_state_e;

  localparam logic ATF_MODE_HIGH   = 1'b0;
  localparam logic ATF_MODE_PERIOD = 1'b1;

endpackage

// File: rtl/atf_sync_edge.sv
// Synchroniser chain for the asynchronous reference plus rise/fall detection.
module atf_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fin,
  output logic fin_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fin_s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fin_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], fin};
      fin_s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    fin_s = sync_q[SYNC_STAGES-1];
    rise  = fin_s & ~fin_s_d;
    fall  = ~fin_s & fin_s_d;
  end

endmodule

// File: rtl/atf_period_meter.sv
// Measures high-time or period of a synchronised reference in clk cycles,
// averages 2^AVG_LOG2 samples and publishes a frequency word.
module atf_period_meter
  import atf_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             fin,
  output logic [CNT_W-1:0] raw_w,
  output logic             raw_vld,
  output logic [CNT_W-1:0] fin_w,
  output logic             fin_w_vld,
  output logic             lost
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NACC_W = AVG_LOG2 + 1;
  localparam logic [NACC_W-1:0] NACC_LAST = NACC_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  atf_state_e state, state_nxt;

  logic              fin_s, rise, fall;
  logic              start_ev, end_ev, mode_d, mode_chg;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic [NACC_W-1:0] nacc;
  logic              do_start, do_sample, do_count, do_timeout, clr_all, clr_avg;

  atf_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .fin   (fin),
    .fin_s (fin_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign start_ev = rise & fin_s;
  assign end_ev   = (mode == ATF_MODE_PERIOD) ? rise : fall;
  assign mode_chg = (mode != mode_d);
  assign acc_sum  = acc + ACC_W'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Priority: en low, then mode change, then end event, then saturation.
  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_sample  = 1'b0;
    do_count   = 1'b0;
    do_timeout = 1'b0;
    clr_all    = 1'b0;
    clr_avg    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      clr_all   = 1'b1;
    end else begin
      unique case (state)
        IDLE: state_nxt = ARM;
        ARM: begin
          if (mode_chg) begin
            clr_avg = 1'b1;
          end else if (start_ev) begin
            do_start  = 1'b1;
            state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (mode_chg) begin
            clr_avg   = 1'b1;
            state_nxt = ARM;
          end else if (end_ev) begin
            do_sample = 1'b1;
            if (mode == ATF_MODE_PERIOD) do_start = 1'b1;
            else                         state_nxt = ARM;
          end else if (cnt == CNT_MAX) begin
            do_timeout = 1'b1;
            state_nxt  = ARM;
          end else begin
            do_count = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_d    <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      nacc      <= '0;
      raw_w     <= '0;
      raw_vld   <= 1'b0;
      fin_w     <= '0;
      fin_w_vld <= 1'b0;
      lost      <= 1'b0;
    end else begin
      mode_d    <= mode;
      raw_vld   <= 1'b0;
      fin_w_vld <= 1'b0;
      if (clr_all) begin
        cnt  <= '0;
        acc  <= '0;
        nacc <= '0;
      end
      if (clr_avg) begin
        acc  <= '0;
        nacc <= '0;
      end
      if (do_count) cnt <= cnt + CNT_W'(1);
      if (do_timeout) begin
        lost <= 1'b1;
        cnt  <= '0;
        acc  <= '0;
        nacc <= '0;
      end
      if (do_sample) begin
        raw_w   <= cnt;
        raw_vld <= 1'b1;
        lost    <= 1'b0;
        if (nacc == NACC_LAST) begin
          fin_w     <= acc_sum[AVG_LOG2 +: CNT_W];
          fin_w_vld <= 1'b1;
          acc       <= '0;
          nacc      <= '0;
        end else begin
          acc  <= acc_sum;
          nacc <= nacc + NACC_W'(1);
        end
      end
      // Period mode restarts the count on the same rise that closed the sample.
      if (do_start) cnt <= CNT_W'(1);
    end
  end

endmodule
